// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decoder handshake,
// and the redirect/halt controls from the control stage.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_opcode, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited memory requests, in-order prefetch FIFO,
// redirect flush with stale-response discard, and halt.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]     DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_q;
  logic          run_q;
  logic [CW-1:0] count_q, out_q, discard_q;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [31:0]   pcq        [FIFO_DEPTH];
  logic [PW-1:0] pcq_wr_q, pcq_rd_q;

  logic credit_ok, accept, rsp, push, pop, redirect;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit counts both buffered and in-flight words, so a response always has a slot.
  assign credit_ok = ({1'b0, count_q} + {1'b0, out_q}) < DEPTH_W;
  assign redirect  = bus.redirect_valid;
  assign accept    = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp       = bus.imem_rsp_valid;
  assign push      = rsp && (discard_q == '0) && !redirect;
  assign pop       = (count_q != '0) && bus.if_ready && !redirect;

  assign bus.imem_req_valid = run_q && !bus.halt && !redirect && credit_ok;
  assign bus.imem_addr      = pc_q;
  assign bus.if_valid       = (count_q != '0);
  assign bus.if_instr       = fifo_instr[head_q];
  assign bus.if_pc          = fifo_pc[head_q];
  assign bus.if_opcode      = bus.if_instr[6:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      run_q     <= 1'b0;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      pcq_wr_q  <= '0;
      pcq_rd_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        pcq[i]        <= '0;
      end
    end else begin
      run_q <= 1'b1;
      out_q <= out_q + CW'(accept) - CW'(rsp);
      if (accept) begin
        pcq[pcq_wr_q] <= pc_q;
        pcq_wr_q      <= ptr_inc(pcq_wr_q);
        pc_q          <= pc_q + 32'd4;
      end
      if (rsp)
        pcq_rd_q <= ptr_inc(pcq_rd_q);
      if (redirect) begin
        // Every request still in flight after this cycle is stale.
        pc_q      <= {bus.redirect_pc[31:2], 2'b00};
        count_q   <= '0;
        head_q    <= '0;
        tail_q    <= '0;
        discard_q <= out_q - CW'(rsp);
      end else begin
        if (rsp && (discard_q != '0))
          discard_q <= discard_q - CW'(1);
        if (push) begin
          fifo_instr[tail_q] <= bus.imem_rsp_data;
          fifo_pc[tail_q]    <= pcq[pcq_rd_q];
          tail_q             <= ptr_inc(tail_q);
        end
        if (pop)
          head_q <= ptr_inc(head_q);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
